// File: rtl/fc_loader_pkg.sv
// Shared types for the fully-connected weight loader: FSM state encoding and index sizing.
package fc_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        ERR    = 2'd3
    } state_t;

    // Index width for a buffer of n words; callers guarantee n >= 2 so the result is never 0.
    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fc_weight_loader.sv
// Streams weight words into a parallel buffer and commits the full vector to the
// fully-connected weight memory with a single one-clock active-low write pulse.
module fc_weight_loader
    import fc_loader_pkg::*;
#(
    parameter int FLATTENED_LENGTH          = 50,
    parameter int FULLYCONNECTED_DATA_WIDTH = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  load_start,
    input  logic                                                  abort,
    input  logic                                                  s_valid,
    input  logic [FULLYCONNECTED_DATA_WIDTH-1:0]                  s_data,
    input  logic                                                  s_last,
    output logic                                                  s_ready,
    output logic [FULLYCONNECTED_DATA_WIDTH*FLATTENED_LENGTH-1:0] fc_weights,
    output logic                                                  fc_wren_n,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  err,
    output state_t                                                dbg_state
);

    localparam int W     = FULLYCONNECTED_DATA_WIDTH;
    localparam int N     = FLATTENED_LENGTH;
    localparam int IDX_W = idx_width(FLATTENED_LENGTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       buf_q [N];
    logic               wren_n_q, wren_n_d;
    logic               done_q, done_d;
    logic               hs;
    logic               at_last;

    // Stream handshake: a word transfers on a posedge where s_valid && s_ready;
    // s_ready depends only on state, and a same-cycle abort cancels the transfer.
    assign hs      = (state_q == LOAD) && s_valid && !abort;
    assign at_last = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wren_n_q <= 1'b1;
            done_q   <= 1'b0;
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wren_n_q <= wren_n_d;
            done_q   <= done_d;
            if (hs) buf_q[idx_q] <= s_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wren_n_d = 1'b1;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (hs) begin
                    if (at_last && s_last) begin
                        state_d  = COMMIT;
                        wren_n_d = 1'b0;
                    end else if (at_last || s_last) begin
                        state_d = ERR;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            ERR: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (load_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word 0 lands in the most significant slot of the flattened vector.
    always_comb begin
        fc_weights = '0;
        for (int i = 0; i < N; i++) fc_weights[(N-1-i)*W +: W] = buf_q[i];
    end

    always_comb begin
        s_ready   = (state_q == LOAD);
        busy      = (state_q == LOAD) || (state_q == COMMIT);
        err       = (state_q == ERR);
        fc_wren_n = wren_n_q;
        done      = done_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_fc_weight_loader.sv
// Directed bench for fc_weight_loader with N=4 words of 8 bits and a negedge-write memory model.
module tb_fc_weight_loader;
    import fc_loader_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           load_start = 1'b0;
    logic           abort = 1'b0;
    logic           s_valid = 1'b0;
    logic [W-1:0]   s_data = '0;
    logic           s_last = 1'b0;
    logic           s_ready;
    logic [N*W-1:0] fc_weights;
    logic           fc_wren_n;
    logic           busy;
    logic           done;
    logic           err;
    state_t         dbg_state;

    int             checks = 0;
    int             failures = 0;
    int             wr_cnt = 0;
    int             wr_base;
    logic [N*W-1:0] mem_q = '0;

    fc_weight_loader #(
        .FLATTENED_LENGTH(N),
        .FULLYCONNECTED_DATA_WIDTH(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_start(load_start),
        .abort(abort),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_last(s_last),
        .s_ready(s_ready),
        .fc_weights(fc_weights),
        .fc_wren_n(fc_wren_n),
        .busy(busy),
        .done(done),
        .err(err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory model: captures the vector on every negedge while the write enable is low.
    always @(negedge clk) begin
        if (rst && !fc_wren_n) begin
            mem_q  = fc_weights;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sends load_start then N back-to-back words (MSB byte first), s_last on the final one.
    // Returns just after the edge that accepted the last word.
    task automatic send_frame(input logic [31:0] frame);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_data  = frame[31-8*i -: 8];
            s_last  = (i == N - 1);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_wren_n", 32'(fc_wren_n), 32'd1);
        check("rst_weights", fc_weights, 32'h0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_ready_busy", {30'd0, s_ready, busy}, 32'd0);
        rst = 1'b1;
        tick();

        // Back-to-back frame with latency checks
        wr_base = wr_cnt;
        send_frame(32'h11223344);
        check("b2b_wren_low", 32'(fc_wren_n), 32'd0);
        check("b2b_weights", fc_weights, 32'h11223344);
        check("b2b_state_commit", 32'(dbg_state), 32'(COMMIT));
        check("b2b_busy_ready", {30'd0, busy, s_ready}, 32'b10);
        check("b2b_done_early", 32'(done), 32'd0);
        tick();
        check("b2b_wren_high", 32'(fc_wren_n), 32'd1);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_mem", mem_q, 32'h11223344);
        check("b2b_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
        tick();
        check("b2b_done_pulse", 32'(done), 32'd0);
        check("b2b_idle", 32'(dbg_state), 32'(IDLE));

        // Same frame sent with bubbles
        wr_base = wr_cnt;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 2 * N - 1; i++) begin
            s_valid = (i % 2 == 0);
            s_data  = (i % 2 == 0) ? 8'(8'h11 * (i / 2 + 1)) : 8'hEE;
            s_last  = (i == 2 * N - 2);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("bub_wren_low", 32'(fc_wren_n), 32'd0);
        check("bub_weights", fc_weights, 32'h11223344);
        tick();
        check("bub_done", 32'(done), 32'd1);
        tick();
        tick();
        check("bub_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);

        // Early s_last on second word
        wr_base = wr_cnt;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0;
        tick();
        s_data = 8'h66; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        check("early_err", 32'(err), 32'd1);
        check("early_ready", 32'(s_ready), 32'd0);
        check("early_state", 32'(dbg_state), 32'(ERR));
        tick();
        tick();
        check("early_err_sticky", 32'(err), 32'd1);
        check("early_no_write", 32'(wr_cnt - wr_base), 32'd0);
        check("early_partial", fc_weights, 32'h55663344);
        send_frame(32'h01020304);
        check("recover_wren_low", 32'(fc_wren_n), 32'd0);
        check("recover_err", 32'(err), 32'd0);
        tick();
        check("recover_done", 32'(done), 32'd1);
        check("recover_mem", mem_q, 32'h01020304);
        check("recover_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);

        // Fourth word without s_last
        wr_base = wr_cnt;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h0A + i);
            s_last  = 1'b0;
            tick();
        end
        s_valid = 1'b0;
        check("miss_err", 32'(err), 32'd1);
        check("miss_wren", 32'(fc_wren_n), 32'd1);
        check("miss_partial", fc_weights, 32'h0A0B0C0D);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("miss_abort_state", 32'(dbg_state), 32'(IDLE));
        check("miss_abort_err", 32'(err), 32'd0);
        check("miss_no_write", 32'(wr_cnt - wr_base), 32'd0);

        // Abort after two words, with a same-cycle word that must not be stored
        wr_base = wr_cnt;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        s_valid = 1'b1; s_data = 8'h77;
        tick();
        s_data = 8'h88;
        tick();
        s_data = 8'h99; abort = 1'b1;
        tick();
        s_valid = 1'b0; abort = 1'b0;
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        check("abort_partial", fc_weights, 32'h77880C0D);
        tick();
        check("abort_no_write", 32'(wr_cnt - wr_base), 32'd0);
        send_frame(32'hA0A1A2A3);
        check("reload_weights", fc_weights, 32'hA0A1A2A3);
        check("reload_wren_low", 32'(fc_wren_n), 32'd0);
        tick();
        check("reload_mem", mem_q, 32'hA0A1A2A3);
        check("reload_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);

        // Asynchronous reset in the middle of a load
        wr_base = wr_cnt;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        s_valid = 1'b1; s_data = 8'hE1;
        tick();
        s_data = 8'hE2;
        tick();
        check("pre_rst_state", 32'(dbg_state), 32'(LOAD));
        #2;
        rst = 1'b0;
        #1;
        check("arst_state", 32'(dbg_state), 32'(IDLE));
        check("arst_wren_n", 32'(fc_wren_n), 32'd1);
        check("arst_weights", fc_weights, 32'h0);
        check("arst_err", 32'(err), 32'd0);
        s_valid = 1'b0;
        #1;
        rst = 1'b1;
        tick();
        tick();
        tick();
        check("arst_idle_after", 32'(dbg_state), 32'(IDLE));
        check("arst_no_write", 32'(wr_cnt - wr_base), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
